// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: N-digit BCD counter with a tick prescaler and a
// time-multiplexed driver for a common-anode 7-segment display.
// The counter holds, counts up, counts down or loads on each prescaler tick;
// the scanner lights one digit at a time and decodes the selected BCD digit.

module bcd_scan_counter #(
  parameter int DIGITS     = 4,
  parameter int DIV_COUNT  = 50000000,
  parameter int SCAN_COUNT = 50000,
  parameter int BLANK_LZ   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic [1:0]            i_mode,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic                  o_tick,
  output logic [4*DIGITS-1:0]   o_count,
  output logic                  o_wrap,
  output logic [DIGITS-1:0]     o_an_n,
  output logic [6:0]            o_seg_out
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

  // Counter widths; a single-state counter still needs one bit of storage.
  localparam int PW = $clog2(DIV_COUNT);
  localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV_COUNT - 1);
  localparam logic [SW-1:0]     SCAN_LAST  = SW'(SCAN_COUNT - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_RESET   = ~DIGITS'(1);

  // Registered state
  logic [PW-1:0]       r_presc;
  logic                r_tick;
  logic [4*DIGITS-1:0] r_count;
  logic                r_wrap;
  logic [SW-1:0]       r_scan;
  logic [IW-1:0]       r_idx;
  logic [DIGITS-1:0]   r_an_n;

  // Combinational helpers
  mode_t               w_mode;
  logic [4*DIGITS-1:0] w_incCount;
  logic                w_incCarry;
  logic [4*DIGITS-1:0] w_decCount;
  logic                w_decBorrow;
  logic [4*DIGITS-1:0] w_loadClamped;
  logic [4*DIGITS-1:0] w_nextCount;
  logic                w_nextWrap;
  logic [IW-1:0]       w_nextIdx;
  logic                w_zeroAbove;
  logic [DIGITS-1:0]   w_blank;
  logic [3:0]          w_digit;
  logic                w_blankNow;

  assign w_mode = mode_t'(i_mode);

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit; non-BCD shows a dash.
  function automatic logic [6:0] decodeSeg(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'd0:    segs = 7'b1000000;
      4'd1:    segs = 7'b1111001;
      4'd2:    segs = 7'b0100100;
      4'd3:    segs = 7'b0110000;
      4'd4:    segs = 7'b0011001;
      4'd5:    segs = 7'b0010010;
      4'd6:    segs = 7'b0000010;
      4'd7:    segs = 7'b1111000;
      4'd8:    segs = 7'b0000000;
      4'd9:    segs = 7'b0010000;
      default: segs = 7'b0111111;
    endcase
    return segs;
  endfunction

  // Free-running prescaler; tick is registered so it pulses once per wrap.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_tick <= (r_presc == PRESC_LAST);
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  // Ripple BCD increment: a carry enters digit 0 and stops at the first non-9.
  always_comb begin
    w_incCount = r_count;
    w_incCarry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_incCarry) begin
        if (r_count[4*i +: 4] >= 4'd9) begin
          w_incCount[4*i +: 4] = 4'd0;
        end else begin
          w_incCount[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
          w_incCarry = 1'b0;
        end
      end
    end
  end

  // Ripple BCD decrement: a borrow enters digit 0 and stops at the first non-0.
  always_comb begin
    w_decCount  = r_count;
    w_decBorrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_decBorrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_decCount[4*i +: 4] = 4'd9;
        end else begin
          w_decCount[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          w_decBorrow = 1'b0;
        end
      end
    end
  end

  // Load value with any non-BCD digit saturated to 9 so the count stays legal.
  always_comb begin
    w_loadClamped = i_load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (i_load_val[4*i +: 4] > 4'd9) begin
        w_loadClamped[4*i +: 4] = 4'd9;
      end
    end
  end

  // Next count and wrap: load acts every edge, up/down only on a tick.
  always_comb begin
    w_nextCount = r_count;
    w_nextWrap  = 1'b0;
    case (w_mode)
      MODE_LOAD: begin
        w_nextCount = w_loadClamped;
      end
      MODE_UP: begin
        if (r_tick) begin
          w_nextCount = w_incCount;
          w_nextWrap  = w_incCarry;
        end
      end
      MODE_DOWN: begin
        if (r_tick) begin
          w_nextCount = w_decCount;
          w_nextWrap  = w_decBorrow;
        end
      end
      default: begin
        w_nextCount = r_count;
      end
    endcase
  end

  // Count and wrap registers.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_nextCount;
      r_wrap  <= w_nextWrap;
    end
  end

  assign w_nextIdx = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);

  // Scan timer; on its wrap the digit index and anode select advance together.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_scan <= '0;
      r_idx  <= '0;
      r_an_n <= AN_RESET;
    end else begin
      if (r_scan == SCAN_LAST) begin
        r_scan <= '0;
        r_idx  <= w_nextIdx;
        r_an_n <= ~(DIGITS'(1) << w_nextIdx);
      end else begin
        r_scan <= r_scan + SW'(1);
      end
    end
  end

  // Leading-zero map: a digit above 0 is blank when it and all higher digits are 0.
  always_comb begin
    w_zeroAbove = 1'b1;
    w_blank     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zeroAbove = w_zeroAbove & (r_count[4*i +: 4] == 4'd0);
      if (i > 0 && BLANK_LZ != 0) begin
        w_blank[i] = w_zeroAbove;
      end
    end
  end

  // Pick the digit currently being lit along with its blanking flag.
  always_comb begin
    w_digit    = r_count[3:0];
    w_blankNow = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_digit    = r_count[4*i +: 4];
        w_blankNow = w_blank[i];
      end
    end
  end

  assign o_seg_out = w_blankNow ? 7'b1111111 : decodeSeg(w_digit);
  assign o_tick    = r_tick;
  assign o_count   = r_count;
  assign o_wrap    = r_wrap;
  assign o_an_n    = r_an_n;

endmodule

// File: doc/bcd_scan_counter.md
Name: bcd_scan_counter

Overview:
- Parametrised successor to the single-digit up/down counter and 7-segment path.
- N-digit BCD counter with hold, up, down and load modes.
- Built-in tick prescaler, wrap pulse, time-multiplexed digit scanning and optional leading-zero blanking.
- Drives a common-anode multi-digit LED display directly from the board clock.

Parameters:
DIGITS, 4, number of BCD digits and anode lines (1..8)
DIV_COUNT, 50000000, clk cycles per count tick (>=2)
SCAN_COUNT, 50000, clk cycles each digit is lit (>=1)
BLANK_LZ, 1, 1 = blank leading zero digits; 0 = show all digits

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous reset, active-high
mode  in  2  00 hold, 01 up, 10 down, 11 load
load_val  in  4*DIGITS  BCD load value, digit 0 in bits [3:0]
tick  out  1  one-cycle prescaler pulse
count  out  4*DIGITS  current BCD count, registered
wrap  out  1  one-cycle pulse on 99..9->0 (up) or 0..0->99..9 (down)
an_n  out  DIGITS  active-low one-hot anode select; bit 0 = least significant digit
seg_out  out  7  active-low segments {g,f,e,d,c,b,a}

Behaviour:
- Reset values (clr high, async): prescaler=0, tick=0, count=0, wrap=0, scan timer=0, digit index=0.
  an_n = all ones except bit0 = 0; seg_out = 7'b1000000.
- Prescaler:
  - Counts 0..DIV_COUNT-1 and wraps.
  - tick is registered: high for exactly one cycle when prescaler wraps, i.e. once every DIV_COUNT cycles.
  - First tick is DIV_COUNT cycles after reset release.
  - Free-running; unaffected by mode.
- Count update, evaluated on every clk edge:
  - mode 11: count <= load_val at the next edge regardless of tick. Any load digit >9 is stored as 9. wrap=0.
  - mode 01 with tick=1: BCD increment. A digit at 9 becomes 0 and carries into the next digit. All-9s becomes all-0s and wrap=1 for one cycle.
  - mode 10 with tick=1: BCD decrement. A digit at 0 becomes 9 and borrows from the next digit. All-0s becomes all-9s and wrap=1 for one cycle.
  - mode 00, or tick=0 with mode 01/10: count holds; wrap=0.
  - Count and wrap update on the edge where tick is sampled high, so they change 1 cycle after the tick assertion cycle.
  - Mode change on the same edge as a tick takes the new mode.
- Scan:
  - Scan timer counts 0..SCAN_COUNT-1.
  - On wrap of the scan timer, the digit index advances 0,1,..,DIGITS-1,0.
  - an_n = ~(1 << index), registered with the index.
  - seg_out is the combinational decode of count digit [index].
- Decode, active-low {g..a}:
  0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  Codes 10-15 are unreachable; they decode to 0111111 (dash).
- Blanking (BLANK_LZ=1):
  - Digit i>0 shows seg_out=1111111 when it and every higher digit are 0.
  - Digit 0 is never blanked.
  - an_n still scans the blanked digit.
- clr asserted mid-operation forces all reset values immediately. Operation resumes from 0 on the first edge after deassertion.
- No combinational path from any input to any output except count to seg_out.

Test Plan:
Use DIGITS=4, DIV_COUNT=4, SCAN_COUNT=2, BLANK_LZ=1 throughout.
1. Reset then mode=01 for 40 cycles -> tick every 4th cycle; count steps 0000,0001,..,0009,0010 after ten ticks; wrap never asserts.
2. Load 9998 then mode=01 -> after tick 1 count=9999; after tick 2 count=0000 with wrap=1 for exactly one cycle.
3. Load 0000 then mode=10 -> after one tick count=9999 with wrap pulse. Load 1000 then one down tick -> count=0999.
4. Load value 0x00A5 (low digit 5, next digit A) -> count=0095 (A clamped to 9). Then mode=00 for 20 cycles -> count unchanged; no wrap.
5. count=0007 -> an_n cycles 1110,1101,1011,0111 every 2 cycles. seg_out=1111000 while digit 0 is lit, 1111111 for digits 1-3. With BLANK_LZ=0, digits 1-3 show 1000000.
6. Assert clr mid-count (count=0042, index=2) -> count=0, an_n=1110, seg_out=1000000 with no clk edge. After release the first tick arrives 4 cycles later.
